// File: rtl/btb_pkg.sv
// Shared types for the BTB write sequencer: update record, table entry, FSM state.
package btb_pkg;

  localparam int BTB_DATA_W = 53;
  localparam int TAG_W      = 20;
  localparam int BTB_IDX_W  = 10;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        mispredict;
  } btb_upd_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
  } btb_entry_t;

  typedef enum logic {
    ST_IDLE,
    ST_SWEEP
  } btb_state_e;

  // A not-taken resolution clears the entry: 1-bit prediction, no hysteresis.
  function automatic btb_entry_t make_entry(input btb_upd_t u);
    btb_entry_t e;
    e.valid  = u.taken;
    e.tag    = u.pc[31:12];
    e.target = u.taken ? u.target : 32'h0;
    return e;
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Small synchronous FIFO of pending BTB updates; storage itself is not reset.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  btb_upd_t      data_i,
  input  logic          pop_i,
  output btb_upd_t      data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  btb_upd_t        mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Push at full is allowed only when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write-port sequencer: invalidate sweep after reset/flush, then buffered EX updates.
// Optional BTB_WRITE_FILTER_EN drops correctly-predicted updates at the handshake.
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int IDX_W      = BTB_IDX_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_upd_valid,
  output logic        o_upd_ready,
  input  logic [31:0] i_upd_pc,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_taken,
  input  logic        i_upd_mispredict,
  input  logic        i_flush_all,
  output logic        o_btb_wren,
  output logic [31:0] o_btb_addr,
  output logic [BTB_DATA_W-1:0] o_btb_data,
  output logic        o_busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

`ifdef BTB_WRITE_FILTER_EN
  localparam logic FILTER_EN = 1'b1;
`else
  localparam logic FILTER_EN = 1'b0;
`endif

  btb_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wren_q, wren_d;
  logic [31:0]      addr_q, addr_d;
  btb_entry_t       data_q, data_d;
  logic             busy_q, busy_d;

  btb_upd_t         upd_in, fifo_head, head;
  logic             fifo_empty, fifo_full;
  logic [CW-1:0]    fifo_count;
  logic             upd_fire, upd_keep, bypass, fifo_push, fifo_pop;

  function automatic logic [31:0] sweep_addr(input logic [IDX_W-1:0] idx);
    return 32'({idx, 2'b00});
  endfunction

  assign o_upd_ready = (fifo_count < CW'(FIFO_DEPTH)) & ~i_reset;
  assign upd_fire    = i_upd_valid & o_upd_ready;
  assign upd_keep    = upd_fire & (i_upd_mispredict | ~FILTER_EN);
  assign upd_in      = '{pc: i_upd_pc, target: i_upd_target,
                         taken: i_upd_taken, mispredict: i_upd_mispredict};
  // An update arriving at an empty FIFO in IDLE is written straight through.
  assign head        = fifo_empty ? upd_in : fifo_head;
  assign fifo_push   = upd_keep & ~bypass & (~fifo_full | fifo_pop);

  btb_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .push_i  (fifo_push),
    .data_i  (upd_in),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wren_d   = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    busy_d   = 1'b0;
    fifo_pop = 1'b0;
    bypass   = 1'b0;
    if (i_flush_all) begin
      // Flush wins over any pop; the sweep write for index 0 goes out now.
      state_d = ST_SWEEP;
      wren_d  = 1'b1;
      addr_d  = sweep_addr('0);
      data_d  = '0;
      idx_d   = IDX_W'(1);
      busy_d  = 1'b1;
    end else begin
      unique case (state_q)
        ST_SWEEP: begin
          wren_d = 1'b1;
          addr_d = sweep_addr(idx_q);
          data_d = '0;
          idx_d  = idx_q + IDX_W'(1);
          busy_d = 1'b1;
          if (idx_q == '1) state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (~fifo_empty | upd_keep) begin
            fifo_pop = ~fifo_empty;
            bypass   = fifo_empty;
            wren_d   = head.mispredict | ~FILTER_EN;
            addr_d   = head.pc;
            data_d   = make_entry(head);
          end
        end
        default: state_d = ST_SWEEP;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_SWEEP;
      idx_q   <= '0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  // Busy stays high through the cycle the final sweep write is presented.
  assign o_busy     = busy_q | (state_q == ST_SWEEP);
  assign o_btb_wren = wren_q;
  assign o_btb_addr = addr_q;
  assign o_btb_data = data_q;

endmodule
